// File: rtl/div_32bits_seq_pkg.sv
// div_32bits_seq_pkg: shared state encoding, iteration count and negation helper.
//    state_t  : IDLE=0, CALC=1, FIX=2, DONE=3
//    DIV_ITER : quotient bits produced, one per CALC cycle
//    neg32    : two's complement negation (~x + 1)
package div_32bits_seq_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
   localparam int DIV_ITER = 32;
   function automatic logic [31:0] neg32(input logic [31:0] x);
      return ~x + 32'd1;
   endfunction
endpackage

// File: rtl/div_32bits_seq_adder.sv
// adder_32bits: 32-bit adder/subtractor.
//    a, b : operands
//    ctr  : 0 = a + b, 1 = a - b (b inverted, carry-in 1)
//    s    : result
//    co   : carry out; in subtract mode 1 means a >= b (no borrow)
module adder_32bits (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        ctr,
   output logic [31:0] s,
   output logic        co
);
   assign {co, s} = {1'b0, a} + {1'b0, b ^ {32{ctr}}} + {32'd0, ctr};
endmodule

// File: rtl/div_32bits_seq.sv
// div_32bits_seq: restoring divider, one quotient bit per clock, signed/unsigned.
//    clk, rst            : clock, asynchronous active-high reset
//    start, sign         : request (sampled in IDLE), 1 = signed operands
//    dividend, divisor   : operands latched with start
//    busy, done          : operation in flight, one-cycle completion pulse
//    quotient, remainder : registered results held until the next result
//    div_zero            : divisor was zero for the last accepted request
module div_32bits_seq
   import div_32bits_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);
   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [31:0] quotient_q, quotient_d, remainder_q, remainder_d;
   logic        sd_q, sd_d, sv_q, sv_d, dz_q, dz_d, div_zero_q, div_zero_d, done_q, done_d;
   logic [31:0] rem_sh, diff;
   logic        co;
   // {msb, rem_sh} is the 33-bit partial remainder after the left shift
   assign rem_sh = {rem_q[30:0], quo_q[31]};
   adder_32bits u_sub (.a(rem_sh), .b(dvs_q), .ctr(1'b1), .s(diff), .co(co));
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      sd_d        = sd_q;
      sv_d        = sv_q;
      dz_d        = dz_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            sd_d       = sign & dividend[31];
            sv_d       = sign & divisor[31];
            quo_d      = sd_d ? neg32(dividend) : dividend;
            dvs_d      = sv_d ? neg32(divisor) : divisor;
            rem_d      = '0;
            cnt_d      = 5'(DIV_ITER - 1);
            dz_d       = divisor == '0;
            div_zero_d = 1'b0;
            state_d    = dz_d ? DONE : CALC;
         end
         CALC: begin
            rem_d   = (co | rem_q[31]) ? diff : rem_sh;
            quo_d   = {quo_q[30:0], co | rem_q[31]};
            cnt_d   = cnt_q - 5'd1;
            state_d = (cnt_q == 5'd0) ? FIX : CALC;
         end
         FIX: begin
            quotient_d  = (sd_q ^ sv_q) ? neg32(quo_q) : quo_q;
            remainder_d = sd_q ? neg32(rem_q) : rem_q;
            state_d     = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
            // quo_q still holds |dividend|; re-negating restores the original value
            if (dz_q) begin
               quotient_d  = '1;
               remainder_d = sd_q ? neg32(quo_q) : quo_q;
               div_zero_d  = 1'b1;
            end
         end
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         sd_q        <= 1'b0;
         sv_q        <= 1'b0;
         dz_q        <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         sd_q        <= sd_d;
         sv_q        <= sv_d;
         dz_q        <= dz_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
         done_q      <= done_d;
      end
   end
   // busy covers CALC/FIX/DONE so it falls on the same edge that raises done
   assign busy      = state_q != IDLE;
   assign done      = done_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;
endmodule

// File: tb/tb_div_32bits_seq.sv
// tb_div_32bits_seq: scoreboard bench for div_32bits_seq with directed vectors.
module tb_div_32bits_seq;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, sgn = 1'b0;
   logic [31:0] dividend = '0, divisor = '0;
   logic        busy, done, div_zero;
   logic [31:0] quotient, remainder;
   int          n_cmp = 0, n_bad = 0, cyc = 0;
   logic        prev_done = 1'b0;
   typedef struct {logic [31:0] q; logic [31:0] r; logic dz; int stamp;} exp_t;
   exp_t sb[$];
   div_32bits_seq dut (.clk(clk), .rst(rst), .start(start), .sign(sgn), .dividend(dividend),
      .divisor(divisor), .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_zero(div_zero));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (done) begin
         chk("done_not_back_to_back", {31'd0, prev_done}, 32'd0);
         if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
            chk("done_cycle", cyc, e.stamp);
         end
      end
      prev_done = done;
   end
   task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q, input logic [31:0] r, input logic dz);
      @(negedge clk);
      sgn = s; dividend = a; divisor = b; start = 1'b1;
      sb.push_back('{q, r, dz, cyc + (dz ? 2 : 35)});
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
   endtask
   task automatic wait_done();
      int n = 0;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
   endtask
   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic dz);
      start_op(s, a, b, q, r, dz);
      wait_done();
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_remainder", remainder, 32'd0);
      chk("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
      rst = 1'b0;
      run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      run_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
      run_op(1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0);
      run_op(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
      run_op(1'b0, 32'hFFFFFFFF, 32'h80000001, 32'd1, 32'h7FFFFFFE, 1'b0);
      run_op(1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1);
      run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
      run_op(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
      run_op(1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1);
      run_op(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      start_op(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
      repeat (4) @(negedge clk);
      sgn = 1'b0; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      start_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_quotient", quotient, 32'd0);
      chk("midrst_remainder", remainder, 32'd0);
      chk("midrst_flags", {29'd0, busy, done, div_zero}, 32'd0);
      sb.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("idle_after_rst", {31'd0, busy}, 32'd0);
      run_op(1'b0, 32'hFFFFFFFF, 32'h80000001, 32'd1, 32'h7FFFFFFE, 1'b0);
      repeat (2) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
